// File: rtl/cache_mem_responder_if.sv
// CPU-side request/response bus of the memory responder.
// The CPU drives the request and holds cpu_cs until the one-cycle cpu_ready pulse.
interface cache_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cpu_cs;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Direct-mapped, write-through, no-write-allocate cache answering CPU requests.
// Read misses and all writes go to the RAM; read hit/miss counts are kept.
module cache_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned INDEX_LSB  = 1,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_mem_responder_if.slave  cpu,
  input  logic                  flush,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int unsigned Lines = 2 ** INDEX_BITS;
  localparam int unsigned LatW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StLookup, StMemRd, StMemWr, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [Lines-1:0]      valid_q, valid_d;

  logic [ADDR_WIDTH-1:0] tag_q  [Lines];
  logic [DATA_WIDTH-1:0] data_q [Lines];

  logic [INDEX_BITS-1:0] idx;
  logic                  hit;
  logic                  lat_last;
  logic                  line_we;
  logic [DATA_WIDTH-1:0] line_wdata;

  assign idx      = addr_q[INDEX_LSB +: INDEX_BITS];
  assign hit      = valid_q[idx] && (tag_q[idx] == addr_q);
  assign lat_last = (lat_q == LatW'(MEM_LAT - 1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ready_d      = 1'b0;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_oe_d     = mem_oe_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    lat_d        = lat_q;
    flush_pend_d = flush_pend_q | flush;
    valid_d      = valid_q;
    line_we      = 1'b0;
    line_wdata   = wdata_q;

    unique case (state_q)
      StIdle: begin
        // A flush (new or pending) takes this cycle; a request waits one more.
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (cpu.cpu_cs) begin
          addr_d  = cpu.cpu_addr;
          we_d    = cpu.cpu_we;
          wdata_d = cpu.cpu_wdata;
          state_d = StLookup;
        end
      end
      StLookup: begin
        lat_d = '0;
        if (!we_q) begin
          if (hit) begin
            rdata_d = data_q[idx];
            hit_d   = (&hit_q) ? hit_q : hit_q + 1'b1;
            ready_d = 1'b1;
            state_d = StResp;
          end else begin
            miss_d     = (&miss_q) ? miss_q : miss_q + 1'b1;
            mem_cs_d   = 1'b1;
            mem_oe_d   = 1'b1;
            mem_addr_d = addr_q;
            state_d    = StMemRd;
          end
        end else begin
          line_we     = hit;
          mem_cs_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = StMemWr;
        end
      end
      StMemRd: begin
        if (lat_last) begin
          rdata_d      = mem_rdata;
          line_we      = 1'b1;
          line_wdata   = mem_rdata;
          valid_d[idx] = 1'b1;
          mem_cs_d     = 1'b0;
          mem_oe_d     = 1'b0;
          ready_d      = 1'b1;
          state_d      = StResp;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StMemWr: begin
        if (lat_last) begin
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = StResp;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      lat_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_oe_q     <= mem_oe_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      lat_q        <= lat_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data need no reset: the valid bit gates every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= addr_q;
      data_q[idx] <= line_wdata;
    end
  end

  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ready = ready_q;
  assign mem_cs        = mem_cs_q;
  assign mem_we        = mem_we_q;
  assign mem_oe        = mem_oe_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: the driver queues expected responses,
// the monitor checks latency, RAM activity and read data on every cpu_ready pulse.
module tb_cache_mem_responder;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          mem_cs, mem_we, mem_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cif ();

  cache_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(4), .INDEX_LSB(1), .MEM_LAT(1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cif.slave), .flush(flush),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // RAM model with one-cycle latency: read data is valid during the oe cycle.
  logic [DW-1:0] ram [0:1023];
  logic          pre_we = 1'b0;
  logic [9:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_cs && mem_we) ram[mem_addr[9:0]] <= mem_wdata;
  end
  assign mem_rdata = mem_oe ? ram[mem_addr[9:0]] : '0;

  typedef struct {
    logic          is_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
    int            oe;
    int            we;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    int   oe_acc;
    int   we_acc;
    exp_t e;
    oe_acc = 0;
    we_acc = 0;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        oe_acc = 0;
        we_acc = 0;
      end else begin
        if (mem_oe) oe_acc++;
        if (mem_we) we_acc++;
        if (mem_cs) chk("mem_addr", 64'(mem_addr), 64'(sbq[0].addr));
        if (mem_we) chk("mem_wdata", 64'(mem_wdata), 64'(sbq[0].data));
      end
      if (cif.cpu_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ready", 64'(cif.cpu_ready), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("latency", 64'(cyc), 64'(e.due));
          chk("mem_oe_cycles", 64'(oe_acc), 64'(e.oe));
          chk("mem_we_cycles", 64'(we_acc), 64'(e.we));
          if (e.is_rd) chk("cpu_rdata", 64'(cif.cpu_rdata), 64'(e.data));
          oe_acc = 0;
          we_acc = 0;
        end
      end
    end
  end

  task automatic req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [DW-1:0] rd, input int lat, input int oe, input int wecnt);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    e.is_rd = !we;
    e.addr  = addr;
    e.data  = we ? wd : rd;
    e.due   = cyc + 1 + lat;
    e.oe    = oe;
    e.we    = wecnt;
    sbq.push_back(e);
    cif.cpu_cs    = 1'b1;
    cif.cpu_we    = we;
    cif.cpu_addr  = addr;
    cif.cpu_wdata = wd;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cif.cpu_ready) got = 1'b1;
    end
    cif.cpu_cs = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: addr 0x%0h got no cpu_ready within 20 cycles", addr);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input bit is_hit);
    if (is_hit) req(1'b0, addr, '0, exp, 1, 0, 0);
    else        req(1'b0, addr, '0, exp, 2, 1, 0);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req(1'b1, addr, data, '0, 2, 0, 1);
  endtask

  task automatic preload(input logic [9:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_oe();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_oe) break;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_ready"}, 64'(cif.cpu_ready), 64'd0);
    chk({tag, "_mem_cs"}, 64'(mem_cs), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_oe"}, 64'(mem_oe), 64'd0);
    chk({tag, "_hit_count"}, 64'(hit_count), 64'd0);
    chk({tag, "_miss_count"}, 64'(miss_count), 64'd0);
    chk({tag, "_cpu_rdata"}, 64'(cif.cpu_rdata), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    cif.cpu_cs    = 1'b0;
    cif.cpu_we    = 1'b0;
    cif.cpu_addr  = '0;
    cif.cpu_wdata = '0;

    preload(10'h100, 32'h1000_011E);
    preload(10'h120, 32'hCAFE_0120);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("reset");

    // 1: cold read miss
    rd(26'h100, 32'h1000_011E, 1'b0);
    chk("t1_miss", 64'(miss_count), 64'd1);
    chk("t1_hit", 64'(hit_count), 64'd0);

    // 2: read hit, no RAM access
    rd(26'h100, 32'h1000_011E, 1'b1);
    chk("t2_hit", 64'(hit_count), 64'd1);

    // 3: write miss goes to RAM without allocating
    wr(26'h11C, 32'h0000_0009);
    chk("t3_ram", 64'(ram[10'h11C]), 64'h9);
    rd(26'h11C, 32'h0000_0009, 1'b0);
    chk("t3_miss", 64'(miss_count), 64'd2);

    // 4: conflicting addresses on index 0, then a write hit
    flush_pulse();
    rd(26'h100, 32'h1000_011E, 1'b0);
    rd(26'h120, 32'hCAFE_0120, 1'b0);
    rd(26'h100, 32'h1000_011E, 1'b0);
    chk("t4_miss", 64'(miss_count), 64'd5);
    chk("t4_hit", 64'(hit_count), 64'd1);
    rd(26'h120, 32'hCAFE_0120, 1'b0);
    wr(26'h120, 32'h1234_5678);
    rd(26'h120, 32'h1234_5678, 1'b1);
    chk("t4_ram", 64'(ram[10'h120]), 64'h1234_5678);
    chk("t4_hit2", 64'(hit_count), 64'd2);

    // 5: flush during a read miss invalidates the freshly filled line
    fork
      rd(26'h100, 32'h1000_011E, 1'b0);
      begin
        wait_oe();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    rd(26'h100, 32'h1000_011E, 1'b0);
    chk("t5_miss", 64'(miss_count), 64'd8);
    chk("t5_hit", 64'(hit_count), 64'd2);

    // 6: reset in the middle of a read miss drops the request
    @(negedge clk);
    cif.cpu_cs   = 1'b1;
    cif.cpu_we   = 1'b0;
    cif.cpu_addr = 26'h11C;
    wait_oe();
    rst_n      = 1'b0;
    cif.cpu_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("midreset");
    rd(26'h100, 32'h1000_011E, 1'b0);
    chk("t6_miss", 64'(miss_count), 64'd1);
    for (int i = 0; i < (2 ** CW) + 3; i++) rd(26'h100, 32'h1000_011E, 1'b1);
    chk("t6_hit_sat", 64'(hit_count), 64'((2 ** CW) - 1));
    chk("t6_miss_after", 64'(miss_count), 64'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
